// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, CPOL/CPHA mode constants and edge-strobe decode.
// Also used by the shift-register block so both sides agree on mode semantics.
package spi_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSetup = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    localparam logic CpolLow         = 1'b0;
    localparam logic CpolHigh        = 1'b1;
    localparam logic CphaSampleLead  = 1'b0;
    localparam logic CphaSampleTrail = 1'b1;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Returns {shift, sample} for an SCK edge. With CPHA=0 the first bit is launched before
    // the first edge, so the final trailing edge has nothing left to shift.
    function automatic logic [1:0] edge_strobes(logic cpha, logic leading, logic last_edge);
        logic [1:0] s;
        if (cpha == CphaSampleLead) begin
            s = leading ? 2'b01 : {~last_edge, 1'b0};
        end else begin
            s = leading ? 2'b10 : 2'b01;
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter timing one SCK half-period; Tc_O flags the last cycle of the period.
module spi_half_period_cnt #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             Clk_I,
    input  logic             RstN_I,
    input  logic             Load_I,
    input  logic [DIV_W-1:0] LoadVal_I,
    input  logic             En_I,
    output logic             Tc_O
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Load_I) begin
            cnt_d = LoadVal_I;
        end else if (En_I && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge Clk_I or negedge RstN_I) begin
        if (!RstN_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tc_O = En_I && (cnt_q == '0);

endmodule

// File: rtl/spi_sck_gen.sv
// SPI master SCK / chip-select / strobe generator for all four CPOL/CPHA modes.
// Configuration is latched at Start; every output comes straight from a register.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk_I,
    input  logic             RstN_I,
    input  logic             Start_I,
    input  logic             Abort_I,
    input  logic             Cpol_I,
    input  logic             Cpha_I,
    input  logic [DIV_W-1:0] HalfDiv_I,
    input  logic [CNT_W-1:0] NumBits_I,
    output logic             SCK_O,
    output logic             CsN_O,
    output logic             Busy_O,
    output logic             Shift_O,
    output logic             Sample_O,
    output logic [CNT_W-1:0] BitIdx_O,
    output logic             Done_O
);

    logic [1:0]       state_q, state_d;
    spi_mode_t        mode_q, mode_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] hm1_q, hm1_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic             sck_q, sck_d;
    logic             csn_q, csn_d;
    logic             busy_q, busy_d;
    logic             shift_q, shift_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] half_m1;
    logic [CNT_W:0]   edge_inc;
    logic [CNT_W:0]   last_edge;
    logic             is_last;
    logic [1:0]       strobes;
    logic             cnt_load;
    logic [DIV_W-1:0] cnt_val;
    logic             tc;

    // A zero divider behaves as one cycle per half-period.
    assign half_m1   = (HalfDiv_I == '0) ? '0 : HalfDiv_I - DIV_W'(1);
    assign edge_inc  = edge_q + (CNT_W + 1)'(1);
    assign last_edge = {n_q, 1'b0};
    assign is_last   = (edge_inc == last_edge);

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .Clk_I     (Clk_I),
        .RstN_I    (RstN_I),
        .Load_I    (cnt_load),
        .LoadVal_I (cnt_val),
        .En_I      (busy_q),
        .Tc_O      (tc)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        n_d      = n_q;
        hm1_d    = hm1_q;
        edge_d   = edge_q;
        sck_d    = sck_q;
        csn_d    = csn_q;
        busy_d   = busy_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        strobes  = 2'b00;
        cnt_load = tc;
        cnt_val  = hm1_q;
        bit_idx_d = (sample_q && (bit_idx_q != n_q)) ? bit_idx_q + CNT_W'(1) : bit_idx_q;

        case (state_q)
            StIdle: begin
                sck_d = Cpol_I;
                if (Start_I && !Abort_I) begin
                    bit_idx_d = '0;
                    if (NumBits_I == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StSetup;
                        mode_d   = '{cpol: Cpol_I, cpha: Cpha_I};
                        n_d      = NumBits_I;
                        hm1_d    = half_m1;
                        edge_d   = '0;
                        csn_d    = 1'b0;
                        busy_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = half_m1;
                        // CPHA=0 launches the first bit while CS settles.
                        shift_d  = (Cpha_I == CphaSampleLead);
                    end
                end
            end
            StSetup, StRun: begin
                if (tc) begin
                    edge_d   = edge_inc;
                    sck_d    = ~sck_q;
                    strobes  = edge_strobes(mode_q.cpha, edge_inc[0], is_last);
                    shift_d  = strobes[1];
                    sample_d = strobes[0];
                    state_d  = is_last ? StHold : StRun;
                end
            end
            StHold: begin
                if (tc) begin
                    state_d = StIdle;
                    csn_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                csn_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (Abort_I && (state_q != StIdle)) begin
            state_d  = StIdle;
            sck_d    = mode_q.cpol;
            csn_d    = 1'b1;
            busy_d   = 1'b0;
            shift_d  = 1'b0;
            sample_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk_I or negedge RstN_I) begin
        if (!RstN_I) begin
            state_q   <= StIdle;
            mode_q    <= '{cpol: CpolLow, cpha: CphaSampleLead};
            n_q       <= '0;
            hm1_q     <= '0;
            edge_q    <= '0;
            bit_idx_q <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= 1'b0;
            sample_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            n_q       <= n_d;
            hm1_q     <= hm1_d;
            edge_q    <= edge_d;
            bit_idx_q <= bit_idx_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            done_q    <= done_d;
        end
    end

    assign SCK_O    = sck_q;
    assign CsN_O    = csn_q;
    assign Busy_O   = busy_q;
    assign Shift_O  = shift_q;
    assign Sample_O = sample_q;
    assign BitIdx_O = bit_idx_q;
    assign Done_O   = done_q;

endmodule

// File: tb/tb_spi_sck_gen.sv
// Scoreboard bench for spi_sck_gen: expected SCK/CS/strobe/done events are queued per transfer
// and a negedge monitor pops and compares each event the DUT produces.
module tb_spi_sck_gen;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 8;

    localparam int EvCsn    = 0;
    localparam int EvSck    = 1;
    localparam int EvShift  = 2;
    localparam int EvSample = 3;
    localparam int EvDone   = 4;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } ev_t;

    logic             Clk_I = 1'b0;
    logic             RstN_I = 1'b0;
    logic             Start_I = 1'b0;
    logic             Abort_I = 1'b0;
    logic             Cpol_I = 1'b0;
    logic             Cpha_I = 1'b0;
    logic [DIV_W-1:0] HalfDiv_I = '0;
    logic [CNT_W-1:0] NumBits_I = '0;
    logic             SCK_O;
    logic             CsN_O;
    logic             Busy_O;
    logic             Shift_O;
    logic             Sample_O;
    logic [CNT_W-1:0] BitIdx_O;
    logic             Done_O;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   arm = 1'b0;
    logic csn_prev = 1'b1;
    logic sck_prev = 1'b0;

    spi_sck_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk_I     (Clk_I),
        .RstN_I    (RstN_I),
        .Start_I   (Start_I),
        .Abort_I   (Abort_I),
        .Cpol_I    (Cpol_I),
        .Cpha_I    (Cpha_I),
        .HalfDiv_I (HalfDiv_I),
        .NumBits_I (NumBits_I),
        .SCK_O     (SCK_O),
        .CsN_O     (CsN_O),
        .Busy_O    (Busy_O),
        .Shift_O   (Shift_O),
        .Sample_O  (Sample_O),
        .BitIdx_O  (BitIdx_O),
        .Done_O    (Done_O)
    );

    always #5 Clk_I = ~Clk_I;
    always @(posedge Clk_I) cyc <= cyc + 1;

    task automatic push(input int c, input int k, input logic v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic note(input int k, input logic v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got kind %0d val %0b at cycle %0d, required no event", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.val != v) begin
                n_bad++;
                $display("FAIL event: got kind %0d val %0b at cycle %0d, required kind %0d val %0b at cycle %0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: fixed per-cycle order CSN, SCK, SHIFT, SAMPLE, DONE.
    always @(negedge Clk_I) begin
        if (arm) begin
            if (CsN_O !== csn_prev) note(EvCsn, CsN_O);
            if (SCK_O !== sck_prev) note(EvSck, SCK_O);
            if (Shift_O)  note(EvShift, 1'b1);
            if (Sample_O) note(EvSample, 1'b1);
            if (Done_O)   note(EvDone, 1'b1);
        end
        csn_prev = CsN_O;
        sck_prev = SCK_O;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk_I);
        #1;
    endtask

    task automatic set_mode(input logic cpol);
        arm = 1'b0;
        Cpol_I = cpol;
        step(3);
        arm = 1'b1;
    endtask

    task automatic drive_start(input logic cpha, input int div, input int n, input logic abort,
                               output int t);
        Cpha_I    = cpha;
        HalfDiv_I = DIV_W'(div);
        NumBits_I = CNT_W'(n);
        Start_I   = 1'b1;
        Abort_I   = abort;
        t         = cyc;
        step(1);
        Start_I   = 1'b0;
        Abort_I   = 1'b0;
    endtask

    // Expected events from the timing equations: edge k at t+1+k*H, done at t+1+(2N+1)*H.
    task automatic push_model(input int t, input logic cpol, input logic cpha, input int h,
                              input int n);
        if (n == 0) begin
            push(t + 1, EvDone, 1'b1);
            return;
        end
        for (int r = 1; r <= (2 * n + 1) * h + 1; r++) begin
            if (r == 1) begin
                push(t + 1, EvCsn, 1'b0);
                if (!cpha) push(t + 1, EvShift, 1'b1);
            end
            if (r > 1 && ((r - 1) % h) == 0 && ((r - 1) / h) <= 2 * n) begin
                int   k;
                logic lead;
                k    = (r - 1) / h;
                lead = ((k % 2) == 1);
                push(t + r, EvSck, cpol ^ lead);
                if (!cpha) begin
                    if (lead) push(t + r, EvSample, 1'b1);
                    else if (k < 2 * n) push(t + r, EvShift, 1'b1);
                end else begin
                    if (lead) push(t + r, EvShift, 1'b1);
                    else push(t + r, EvSample, 1'b1);
                end
            end
            if (r == (2 * n + 1) * h + 1) begin
                push(t + r, EvCsn, 1'b1);
                push(t + r, EvDone, 1'b1);
            end
        end
    endtask

    initial begin
        int t;
        int t2;

        step(3);
        check("rst_sck", SCK_O, 0);
        check("rst_csn", CsN_O, 1);
        check("rst_busy", Busy_O, 0);
        check("rst_shift", Shift_O, 0);
        check("rst_sample", Sample_O, 0);
        check("rst_bitidx", BitIdx_O, 0);
        check("rst_done", Done_O, 0);
        RstN_I = 1'b1;
        step(2);
        set_mode(1'b0);

        // Mode 0, H=2, N=3: hand-computed event list
        drive_start(1'b0, 2, 3, 1'b0, t);
        push(t + 1, EvCsn, 1'b0);     push(t + 1, EvShift, 1'b1);
        push(t + 3, EvSck, 1'b1);     push(t + 3, EvSample, 1'b1);
        push(t + 5, EvSck, 1'b0);     push(t + 5, EvShift, 1'b1);
        push(t + 7, EvSck, 1'b1);     push(t + 7, EvSample, 1'b1);
        push(t + 9, EvSck, 1'b0);     push(t + 9, EvShift, 1'b1);
        push(t + 11, EvSck, 1'b1);    push(t + 11, EvSample, 1'b1);
        push(t + 13, EvSck, 1'b0);
        push(t + 15, EvCsn, 1'b1);    push(t + 15, EvDone, 1'b1);
        check("mode0_busy_t1", Busy_O, 1);
        step(16);
        check("mode0_bitidx", BitIdx_O, 3);
        drain("mode0");

        // Mode 3, H=1, N=8
        set_mode(1'b1);
        check("mode3_idle_high", SCK_O, 1);
        drive_start(1'b1, 1, 8, 1'b0, t);
        push_model(t, 1'b1, 1'b1, 1, 8);
        step(20);
        check("mode3_bitidx", BitIdx_O, 8);
        drain("mode3");

        // HalfDiv 0 and 1 give the same waveform
        set_mode(1'b0);
        drive_start(1'b1, 0, 4, 1'b0, t);
        push_model(t, 1'b0, 1'b1, 1, 4);
        step(12);
        drain("div0");
        drive_start(1'b1, 1, 4, 1'b0, t);
        push_model(t, 1'b0, 1'b1, 1, 4);
        step(12);
        drain("div1");

        // N=0: only a done pulse
        drive_start(1'b0, 3, 0, 1'b0, t);
        push_model(t, 1'b0, 1'b0, 3, 0);
        check("n0_busy", Busy_O, 0);
        step(6);
        drain("n0");

        // Abort in RUN after edge 3 (edge 3 at t+7, abort during t+8)
        drive_start(1'b0, 2, 3, 1'b0, t);
        push(t + 1, EvCsn, 1'b0);     push(t + 1, EvShift, 1'b1);
        push(t + 3, EvSck, 1'b1);     push(t + 3, EvSample, 1'b1);
        push(t + 5, EvSck, 1'b0);     push(t + 5, EvShift, 1'b1);
        push(t + 7, EvSck, 1'b1);     push(t + 7, EvSample, 1'b1);
        push(t + 9, EvCsn, 1'b1);     push(t + 9, EvSck, 1'b0);
        step(7);
        Abort_I = 1'b1;
        step(1);
        Abort_I = 1'b0;
        check("abort_busy", Busy_O, 0);
        check("abort_csn", CsN_O, 1);
        check("abort_sck", SCK_O, 0);
        check("abort_shift", Shift_O, 0);
        check("abort_done", Done_O, 0);
        step(10);
        drain("abort");

        // Start and Abort together in IDLE
        drive_start(1'b0, 2, 3, 1'b1, t);
        check("startabort_busy", Busy_O, 0);
        check("startabort_csn", CsN_O, 1);
        step(10);
        drain("startabort");

        // Mode 2, H=3, N=2 with Start and config changes while busy
        set_mode(1'b1);
        drive_start(1'b0, 3, 2, 1'b0, t);
        push_model(t, 1'b1, 1'b0, 3, 2);
        step(3);
        Start_I   = 1'b1;
        HalfDiv_I = DIV_W'(7);
        NumBits_I = CNT_W'(5);
        Cpha_I    = 1'b1;
        step(1);
        Start_I   = 1'b0;
        step(4);
        HalfDiv_I = DIV_W'(1);
        step(10);
        drain("busy_ignore");

        // Back-to-back: second Start in the Done cycle
        set_mode(1'b0);
        drive_start(1'b0, 1, 2, 1'b0, t);
        push_model(t, 1'b0, 1'b0, 1, 2);
        step(5);
        drive_start(1'b0, 1, 2, 1'b0, t2);
        push_model(t2, 1'b0, 1'b0, 1, 2);
        step(10);
        drain("b2b");

        // Asynchronous reset mid-RUN, then a fresh transfer
        set_mode(1'b1);
        arm = 1'b0;
        drive_start(1'b0, 2, 4, 1'b0, t);
        step(7);
        check("pre_rst_bitidx", BitIdx_O, 2);
        #2;
        RstN_I = 1'b0;
        #1;
        check("arst_sck", SCK_O, 0);
        check("arst_csn", CsN_O, 1);
        check("arst_busy", Busy_O, 0);
        check("arst_bitidx", BitIdx_O, 0);
        check("arst_strobes", {Shift_O, Sample_O, Done_O}, 0);
        @(posedge Clk_I);
        #1;
        RstN_I = 1'b1;
        step(3);
        arm = 1'b1;
        drive_start(1'b0, 2, 4, 1'b0, t);
        push_model(t, 1'b1, 1'b0, 2, 4);
        step(21);
        check("post_rst_bitidx", BitIdx_O, 4);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_sck_gen.md
# spi_sck_gen

Runtime-configurable SPI master clock/framing generator, all four SPI modes (CPOL/CPHA selected per transfer). Produces SCK, an active-low chip select with one half-period of setup and hold, and single-cycle sample/shift strobes aligned to the SCK edges. Sits between the DDS register-write controller and the SPI shift register, and supports transfers of 1 to 2^CNT_W−1 bits at a divider chosen per transfer.

## Interface
- DIV_W, 16, width of half-period divider input
- CNT_W, 8, width of bit-count input and BitIdx_O
---
- Clk_I  in  1  system clock
- RstN_I  in  1  asynchronous active-low reset
- Start_I  in  1  transfer request; honoured only in IDLE
- Abort_I  in  1  terminate transfer; wins over Start_I
- Cpol_I  in  1  SCK idle level; latched at Start
- Cpha_I  in  1  0: sample leading / shift trailing edge; 1: shift leading / sample trailing; latched at Start
- HalfDiv_I  in  DIV_W  SCK half-period H in Clk_I cycles; 0 treated as 1; latched at Start
- NumBits_I  in  CNT_W  bits N per transfer; latched at Start
- SCK_O  out  1  SPI clock
- CsN_O  out  1  chip select, active low
- Busy_O  out  1  transfer in progress
- Shift_O  out  1  one-cycle strobe: launch next bit
- Sample_O  out  1  one-cycle strobe: capture bit
- BitIdx_O  out  CNT_W  number of Sample_O pulses issued in current transfer
- Done_O  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, RUN, HOLD. All outputs registered.
- Reset: state IDLE, SCK_O=0, CsN_O=1, Busy_O=0, Shift_O=0, Sample_O=0, BitIdx_O=0, Done_O=0, latched CPOL=0.
- IDLE: SCK_O follows Cpol_I (one-cycle register delay). Start_I with N≠0 latches config, goes to SETUP; BitIdx_O cleared.
- Start_I with N=0: no CS/SCK activity; Done_O pulses next cycle, stays IDLE.
- SETUP: H cycles, CsN_O=0, SCK_O=CPOL; then RUN.
- RUN: 2N SCK edges, each level held exactly H cycles; odd edges leading, even edges trailing. The last edge returns SCK_O to CPOL and enters HOLD.
- HOLD: H cycles, counted from the last edge, then IDLE with CsN_O=1 and Done_O=1 in the same cycle.
- Strobes: exactly N Shift_O and N Sample_O per transfer.
  - CPHA=0: Shift_O in first SETUP cycle and with trailing edges 1..N−1; Sample_O with each leading edge.
  - CPHA=1: Shift_O with each leading edge; Sample_O with each trailing edge.
- BitIdx_O increments in the cycle after each Sample_O and saturates at N.
- Start_I while Busy_O is ignored.
- Abort_I in any non-IDLE state: next cycle IDLE, SCK_O=CPOL, CsN_O=1, strobes 0, Busy_O=0, no Done_O.

## Timing
- Start in cycle t: CsN_O low and Busy_O high from t+1.
- First SCK edge at t+1+H; edge k at t+1+k·H; last edge at t+1+2N·H.
- CsN_O high and Done_O high at t+1+(2N+1)·H. Busy_O is low in that cycle. Total latency from Start to Done is (2N+1)·H+1 cycles.
- Strobes are asserted in the same cycle SCK_O shows the corresponding edge, except the CPHA=0 pre-shift at t+1.
- H=1: SCK toggles every cycle and runs at Clk_I/2. Arithmetic is unsigned; the half-period counter is DIV_W bits wide and reloads at H−1.
- Back-to-back: a Start in the Done_O cycle is accepted, giving CsN_O high for exactly one cycle.

## Structure
- Package spi_pkg: state encoding (IDLE/SETUP/RUN/HOLD) and CPOL/CPHA mode constants, shared with the shift-register block.
- One sub-module, spi_half_period_cnt: loadable DIV_W down-counter with enable and terminal-count pulse. FSM, edge counter (CNT_W+1 bits, counting 2N) and strobe logic live in the top.

## Test plan
- Mode 0, H=2, N=3, Start at cycle 0:
  - CsN_O low 1..14; SCK_O edges at 3,5,7,9,11,13.
  - Shift_O at 1,5,9; Sample_O at 3,7,11.
  - Done_O at 15; BitIdx_O ends at 3.
- Mode 3 (CPOL=1, CPHA=1), H=1, N=8: SCK_O idles high; 16 edges at cycles 2..17; Shift_O on falling edges, Sample_O on rising edges; Done_O at cycle 18.
- HalfDiv_I=0 vs HalfDiv_I=1 with N=4: identical waveforms. Start with N=0: Done_O at t+1, CsN_O never low.
- Abort_I in RUN after edge 3: next cycle SCK_O=CPOL, CsN_O=1, Busy_O=0, no Done_O. Start and Abort in the same IDLE cycle: no transfer.
- Start during Busy_O is ignored. Start in the Done_O cycle begins a new transfer with CsN_O high for one cycle. HalfDiv_I changed mid-transfer has no effect.
- RstN_I asserted mid-RUN: all outputs take reset values immediately (asynchronous); after release, a fresh Start behaves normally.
